processor_8085_ctrl: RTL

- Multi-cycle fetch/decode/execute sequencer for the 8085-subset datapath (register file of B,C,D,E,H,L plus accumulator, ALU, cy/z flags).
- Replaces hard-wired single-cycle control: owns the PC, drives the instruction memory, and issues one-cycle register-file, ALU, accumulator and flag strobes per instruction.
- Sits between the instruction memory and the existing register file / ALU / accumulator datapath.

---
 rtl/processor_8085_ctrl.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/processor_8085_ctrl.sv
// processor_8085_ctrl
//   Multi-cycle fetch/decode/execute sequencer for the 8085-subset datapath.
//   Owns the program counter and drives the instruction memory. For each
//   instruction it issues one-cycle register-file, accumulator, ALU and flag
//   strobes to the existing datapath.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   run       in   sampled only in FETCH; while 0 no new instruction starts
//   mem_data  in   instruction memory read data, valid the cycle after mem_rd
//   cy, z     in   carry / zero flags from the datapath (for conditional jumps)
//   mem_rd    out  instruction memory read strobe
//   mem_addr  out  read address (always equal to pc)
//   pc        out  program counter
//   rf_ra     out  register read index, 0..5 = B..L, 7 = accumulator
//   rf_wa     out  register write index, same encoding
//   rf_we     out  register-file write enable (destinations 0..5)
//   acc_we    out  accumulator write enable
//   alu_op    out  0 ADD,1 ADC,2 SUB,3 SBB,4 ANA,5 XRA,6 ORA,7 CMP
//   alu_src   out  ALU B operand: 0 register, 1 immediate
//   wb_sel    out  write-back source: 0 ALU, 1 reg read, 2 imm, 3 INR/DCR
//   inc_dec   out  0 INR, 1 DCR
//   flag_we   out  flag update enable
//   imm       out  latched first operand byte
//   halted    out  high while in HALT
//   illegal   out  one-cycle pulse in EXEC on an unsupported opcode
//
// state  | meaning
// -------+------------------------------------------------------------
// FETCH  | wait for run, read opcode at pc
// DECODE | latch opcode, choose operand fetch / exec / halt
// OPND   | read next operand byte at pc
// OPLAT  | latch operand byte (only the first one is kept)
// EXEC   | single cycle of datapath strobes, jumps load pc
// HALT   | parked until reset, no reads

module processor_8085_ctrl #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic [7:0]      mem_data,
  input  logic            cy,
  input  logic            z,
  output logic            mem_rd,
  output logic [PC_W-1:0] mem_addr,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      rf_ra,
  output logic [2:0]      rf_wa,
  output logic            rf_we,
  output logic            acc_we,
  output logic [2:0]      alu_op,
  output logic            alu_src,
  output logic [1:0]      wb_sel,
  output logic            inc_dec,
  output logic            flag_we,
  output logic [7:0]      imm,
  output logic            halted,
  output logic            illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_OPND   = 3'd2,
    S_OPLAT  = 3'd3,
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [7:0] OP_HLT = 8'h76;
  localparam logic [2:0] R_M    = 3'd6;
  localparam logic [2:0] R_A    = 3'd7;

  state_t     state, state_nxt;
  logic [7:0] ir;
  logic [1:0] rem;        // operand bytes still to be fetched
  logic       first_opnd; // next OPLAT holds the byte that goes to imm
  logic       pc_inc;
  logic       jump_take;
  logic [2:0] dst;
  logic [2:0] src;

  assign dst      = ir[5:3];
  assign src      = ir[2:0];
  assign mem_addr = pc;

  // Number of operand bytes following an opcode. Forms naming M are
  // unsupported and therefore treated as single-byte instructions.
  function automatic logic [1:0] opnd_cnt(input logic [7:0] op);
    logic [1:0] n;
    n = 2'd0;
    if (op == 8'hC3 || op == 8'hC2 || op == 8'hCA || op == 8'hD2 || op == 8'hDA)
      n = 2'd2;
    else if (op[7:6] == 2'b00 && op[2:0] == 3'b110 && op[5:3] != R_M)
      n = 2'd1;
    else if (op[7:6] == 2'b11 && op[2:0] == 3'b110)
      n = 2'd1;
    return n;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      ir         <= 8'h00;
      imm        <= 8'h00;
      rem        <= 2'd0;
      first_opnd <= 1'b0;
    end else begin
      if (pc_inc)
        pc <= pc + PC_W'(1);
      else if (jump_take)
        pc <= PC_W'(imm);

      if (state == S_DECODE) begin
        ir         <= mem_data;
        rem        <= opnd_cnt(mem_data);
        first_opnd <= 1'b1;
      end

      if (state == S_OPLAT) begin
        // the second byte of a jump is the high address; PC fits in imm
        if (first_opnd) imm <= mem_data;
        first_opnd <= 1'b0;
        rem        <= rem - 2'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    pc_inc    = 1'b0;
    jump_take = 1'b0;
    rf_ra     = 3'd0;
    rf_wa     = 3'd0;
    rf_we     = 1'b0;
    acc_we    = 1'b0;
    alu_op    = 3'd0;
    alu_src   = 1'b0;
    wb_sel    = 2'd0;
    inc_dec   = 1'b0;
    flag_we   = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;

    case (state)
      S_FETCH: begin
        if (run) begin
          mem_rd    = 1'b1;
          pc_inc    = 1'b1;
          state_nxt = S_DECODE;
        end
      end

      S_DECODE: begin
        if (mem_data == OP_HLT)
          state_nxt = S_HALT;
        else if (opnd_cnt(mem_data) != 2'd0)
          state_nxt = S_OPND;
        else
          state_nxt = S_EXEC;
      end

      S_OPND: begin
        mem_rd    = 1'b1;
        pc_inc    = 1'b1;
        state_nxt = S_OPLAT;
      end

      S_OPLAT: begin
        state_nxt = (rem > 2'd1) ? S_OPND : S_EXEC;
      end

      S_EXEC: begin
        state_nxt = S_FETCH;
        casez (ir)
          8'b0000_0000: ;  // NOP
          8'b01??_????: begin  // MOV d,s
            if (dst == R_M || src == R_M) begin
              illegal = 1'b1;
            end else begin
              rf_ra  = src;
              rf_wa  = dst;
              wb_sel = 2'd1;
              rf_we  = (dst != R_A);
              acc_we = (dst == R_A);
            end
          end
          8'b00??_?110: begin  // MVI d
            if (dst == R_M) begin
              illegal = 1'b1;
            end else begin
              rf_wa  = dst;
              wb_sel = 2'd2;
              rf_we  = (dst != R_A);
              acc_we = (dst == R_A);
            end
          end
          8'b00??_?10?: begin  // INR d / DCR d
            if (dst == R_M) begin
              illegal = 1'b1;
            end else begin
              rf_ra   = dst;
              rf_wa   = dst;
              wb_sel  = 2'd3;
              inc_dec = ir[0];
              rf_we   = (dst != R_A);
              acc_we  = (dst == R_A);
              flag_we = 1'b1;
            end
          end
          8'b10??_????: begin  // ALU r
            if (src == R_M) begin
              illegal = 1'b1;
            end else begin
              rf_ra   = src;
              rf_wa   = R_A;
              alu_op  = dst;
              acc_we  = (dst != 3'd7);  // CMP only updates flags
              flag_we = 1'b1;
            end
          end
          8'b11??_?110: begin  // ALU immediate
            rf_wa   = R_A;
            alu_op  = dst;
            alu_src = 1'b1;
            acc_we  = (dst != 3'd7);
            flag_we = 1'b1;
          end
          8'hC3: jump_take = 1'b1;
          8'hC2: jump_take = ~z;
          8'hCA: jump_take = z;
          8'hD2: jump_take = ~cy;
          8'hDA: jump_take = cy;
          default: illegal = 1'b1;
        endcase
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: state_nxt = S_FETCH;
    endcase
  end

endmodule
